// File: rtl/axi4lite_char_pkg.sv
// Shared definitions for the character-register AXI4-Lite responder:
// response codes, write/read FSM state types and the byte-strobe merge helper.
package axi4lite_char_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } writeState_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } readState_e;

    // Merge a new 32-bit word into an old one, taking only the bytes whose strobe is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] oldVal,
                                                input logic [31:0] newVal,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[b*8 +: 8] = newVal[b*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axi4lite_char_reg_slave.sv
// AXI4-Lite responder fronting a small bank of 32-bit control/character registers.
// Address and data of a write are captured independently and committed together;
// reads are fully independent of writes and always see the pre-commit register value.
module axi4lite_char_reg_slave
    import axi4lite_char_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic                    rstDone_q;

    writeState_e             wState_q;
    logic                    awHold_q;
    logic                    wHold_q;
    logic [IDX_W-1:0]        awIdx_q;
    logic [DATA_WIDTH-1:0]   wData_q;
    logic [DATA_WIDTH/8-1:0] wStrb_q;
    logic                    bValid_q;
    logic [1:0]              bResp_q;
    logic [NUM_REGS-1:0]     wrPulse_q;

    readState_e              rState_q;
    logic                    rValid_q;
    logic [1:0]              rResp_q;
    logic [DATA_WIDTH-1:0]   rData_q;

    logic                    awReady;
    logic                    wReady;
    logic                    arReady;
    logic                    awFire;
    logic                    wFire;
    logic                    arFire;
    logic                    commit;
    logic [IDX_W-1:0]        commitIdx;
    logic [DATA_WIDTH-1:0]   commitData;
    logic [DATA_WIDTH/8-1:0] commitStrb;
    logic                    commitInRange;
    logic [IDX_W-1:0]        arIdx;
    logic                    arInRange;
    logic [DATA_WIDTH-1:0]   rdMux;
    logic                    unusedSignals;

    // Protection bits and the byte offset within a word carry no meaning here.
    assign unusedSignals = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // READYs stay low until the first clock edge after reset is released.
    assign awReady = rstDone_q && (wState_q == W_IDLE) && !awHold_q;
    assign wReady  = rstDone_q && (wState_q == W_IDLE) && !wHold_q;
    assign arReady = rstDone_q && (rState_q == R_IDLE);

    assign awFire = S_AXI_AWVALID && awReady;
    assign wFire  = S_AXI_WVALID && wReady;
    assign arFire = S_AXI_ARVALID && arReady;

    // A write commits in the cycle where the later of AW/W is seen (held or live).
    assign commit        = (wState_q == W_IDLE) && (awHold_q || awFire) && (wHold_q || wFire);
    assign commitIdx     = awFire ? S_AXI_AWADDR[ADDR_WIDTH-1:2] : awIdx_q;
    assign commitData    = wFire ? S_AXI_WDATA : wData_q;
    assign commitStrb    = wFire ? S_AXI_WSTRB : wStrb_q;
    assign commitInRange = int'(commitIdx) < NUM_REGS;

    assign arIdx     = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign arInRange = int'(arIdx) < NUM_REGS;

    // Read data selection from the current (pre-commit) register contents; unmatched indices read zero.
    always_comb begin
        rdMux = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (arIdx == IDX_W'(k)) begin
                rdMux = regs_q[k];
            end
        end
    end

    // Write FSM: collect AW and W into holding registers, commit once both are present, then hold B until accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstDone_q <= 1'b0;
            wState_q  <= W_IDLE;
            awHold_q  <= 1'b0;
            wHold_q   <= 1'b0;
            awIdx_q   <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            bValid_q  <= 1'b0;
            bResp_q   <= RESP_OKAY;
            wrPulse_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            rstDone_q <= 1'b1;
            wrPulse_q <= '0;
            case (wState_q)
                W_IDLE: begin
                    if (awFire) begin
                        awHold_q <= 1'b1;
                        awIdx_q  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
                    end
                    if (wFire) begin
                        wHold_q <= 1'b1;
                        wData_q <= S_AXI_WDATA;
                        wStrb_q <= S_AXI_WSTRB;
                    end
                    if (commit) begin
                        bValid_q <= 1'b1;
                        bResp_q  <= commitInRange ? RESP_OKAY : RESP_SLVERR;
                        wState_q <= W_RESP;
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (commitIdx == IDX_W'(k)) begin
                                regs_q[k]    <= apply_wstrb(regs_q[k], commitData, commitStrb);
                                wrPulse_q[k] <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bValid_q <= 1'b0;
                        awHold_q <= 1'b0;
                        wHold_q  <= 1'b0;
                        wState_q <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Read FSM: register data/response on the AR handshake and hold them until R is accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rState_q <= R_IDLE;
            rValid_q <= 1'b0;
            rResp_q  <= RESP_OKAY;
            rData_q  <= '0;
        end else begin
            case (rState_q)
                R_IDLE: begin
                    if (arFire) begin
                        rData_q  <= rdMux;
                        rResp_q  <= arInRange ? RESP_OKAY : RESP_SLVERR;
                        rValid_q <= 1'b1;
                        rState_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rValid_q <= 1'b0;
                        rState_q <= R_IDLE;
                    end
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : gRegsOut
            assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
        end
    endgenerate

    assign S_AXI_AWREADY = awReady;
    assign S_AXI_WREADY  = wReady;
    assign S_AXI_ARREADY = arReady;
    assign S_AXI_BVALID  = bValid_q;
    assign S_AXI_BRESP   = bResp_q;
    assign S_AXI_RVALID  = rValid_q;
    assign S_AXI_RRESP   = rResp_q;
    assign S_AXI_RDATA   = rData_q;
    assign wr_pulse_o    = wrPulse_q;

endmodule

// File: tb/tb_axi4lite_char_reg_slave.sv
// Bench for the AXI4-Lite character register responder.
// Two instances share every input: one with four registers, one with three so that
// index 3 decodes as out-of-range. A register-array model tracks expected contents.
module tb_axi4lite_char_reg_slave;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [3:0]   AWADDR;
    logic [2:0]   AWPROT;
    logic         AWVALID;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         BREADY;
    logic [3:0]   ARADDR;
    logic [2:0]   ARPROT;
    logic         ARVALID;
    logic         RREADY;

    logic         AWREADY4, WREADY4, BVALID4, ARREADY4, RVALID4;
    logic [1:0]   BRESP4, RRESP4;
    logic [31:0]  RDATA4;
    logic [127:0] regsO4;
    logic [3:0]   pulse4;

    logic         AWREADY3, WREADY3, BVALID3, ARREADY3, RVALID3;
    logic [1:0]   BRESP3, RRESP3;
    logic [31:0]  RDATA3;
    logic [95:0]  regsO3;
    logic [2:0]   pulse3;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] model4 [4];
    logic [31:0] model3 [3];

    typedef struct {
        logic        isWrite;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          awDly;
        int          wDly;
        logic [31:0] expData4;
        logic [31:0] expData3;
        logic [1:0]  expResp4;
        logic [1:0]  expResp3;
    } vector_t;

    vector_t vecs [13];

    always #5 ACLK = ~ACLK;

    axi4lite_char_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4)) dut4 (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY4),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY4),
        .S_AXI_BRESP(BRESP4), .S_AXI_BVALID(BVALID4), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY4),
        .S_AXI_RDATA(RDATA4), .S_AXI_RRESP(RRESP4), .S_AXI_RVALID(RVALID4), .S_AXI_RREADY(RREADY),
        .regs_o(regsO4), .wr_pulse_o(pulse4)
    );

    axi4lite_char_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(3)) dut3 (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY3),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY3),
        .S_AXI_BRESP(BRESP3), .S_AXI_BVALID(BVALID3), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY3),
        .S_AXI_RDATA(RDATA3), .S_AXI_RRESP(RRESP3), .S_AXI_RVALID(RVALID3), .S_AXI_RREADY(RREADY),
        .regs_o(regsO3), .wr_pulse_o(pulse3)
    );

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Byte-lane merge expressed as a mask over the whole word.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal, input logic [31:0] newVal,
                                               input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (oldVal & ~mask) | (newVal & mask);
    endfunction

    task automatic checkRegs(input string tag);
        for (int k = 0; k < 4; k++) checkOutput({tag, " regs4"}, regsO4[k*32 +: 32], model4[k]);
        for (int k = 0; k < 3; k++) checkOutput({tag, " regs3"}, regsO3[k*32 +: 32], model3[k]);
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                 input int awDly, input int wDly, input int bHold,
                                 output logic [1:0] resp4, output logic [1:0] resp3);
        int   idx;
        int   cyc;
        logic awDone, wDone, awFire, wFire;
        logic [3:0] expP4;
        logic [2:0] expP3;
        logic [1:0] expR3;
        idx    = int'(addr[3:2]);
        expP4  = 4'b0001 << idx;
        expP3  = (idx < 3) ? (3'b001 << idx) : 3'b000;
        expR3  = (idx < 3) ? 2'b00 : 2'b10;
        AWADDR = addr;
        WDATA  = data;
        WSTRB  = strb;
        awDone = 1'b0;
        wDone  = 1'b0;
        cyc    = 0;
        while (!(awDone && wDone) && cyc < 40) begin
            AWVALID = !awDone && (cyc >= awDly);
            WVALID  = !wDone && (cyc >= wDly);
            if (awDone) checkOutput("awready while aw held", AWREADY4, 1'b0);
            if (wDone)  checkOutput("wready while w held", WREADY4, 1'b0);
            awFire = AWVALID && AWREADY4;
            wFire  = WVALID && WREADY4;
            if ((awDone || awFire) && (wDone || wFire)) checkOutput("bvalid before commit", BVALID4, 1'b0);
            @(posedge ACLK); #1;
            awDone = awDone || awFire;
            wDone  = wDone || wFire;
            cyc++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        checkOutput("write handshake within budget", awDone && wDone, 1'b1);
        model4[idx] = mergeBytes(model4[idx], data, strb);
        if (idx < 3) model3[idx] = mergeBytes(model3[idx], data, strb);
        resp4 = BRESP4;
        resp3 = BRESP3;
        checkOutput("bvalid4 after commit", BVALID4, 1'b1);
        checkOutput("bvalid3 after commit", BVALID3, 1'b1);
        checkOutput("bresp4", BRESP4, 2'b00);
        checkOutput("bresp3", BRESP3, expR3);
        checkOutput("pulse4", pulse4, expP4);
        checkOutput("pulse3", pulse3, expP3);
        checkRegs("after commit");
        for (int h = 0; h < bHold; h++) begin
            AWVALID = 1'b1;
            WVALID  = 1'b1;
            WDATA   = ~data;
            checkOutput("awready during bhold", AWREADY4, 1'b0);
            checkOutput("wready during bhold", WREADY4, 1'b0);
            @(posedge ACLK); #1;
            checkOutput("bvalid4 held", BVALID4, 1'b1);
            checkOutput("bvalid3 held", BVALID3, 1'b1);
            checkOutput("bresp4 held", BRESP4, 2'b00);
            checkOutput("bresp3 held", BRESP3, expR3);
            checkOutput("pulse4 during bhold", pulse4, 4'b0000);
            checkRegs("during bhold");
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b1;
        @(posedge ACLK); #1;
        BREADY  = 1'b0;
        checkOutput("bvalid4 cleared", BVALID4, 1'b0);
        checkOutput("pulse4 one cycle", pulse4, 4'b0000);
        checkOutput("awready back", AWREADY4, 1'b1);
    endtask

    task automatic readTxn(input logic [3:0] addr, input int rHold,
                           output logic [31:0] d4, output logic [31:0] d3,
                           output logic [1:0] r4, output logic [1:0] r3);
        int cyc;
        ARADDR  = addr;
        ARVALID = 1'b1;
        cyc     = 0;
        while (!ARREADY4 && cyc < 40) begin
            @(posedge ACLK); #1;
            cyc++;
        end
        checkOutput("arready within budget", ARREADY4, 1'b1);
        checkOutput("rvalid before ar", RVALID4, 1'b0);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        checkOutput("rvalid4 after ar", RVALID4, 1'b1);
        checkOutput("rvalid3 after ar", RVALID3, 1'b1);
        d4 = RDATA4;
        d3 = RDATA3;
        r4 = RRESP4;
        r3 = RRESP3;
        for (int h = 0; h < rHold; h++) begin
            ARVALID = 1'b1;
            ARADDR  = addr ^ 4'h4;
            checkOutput("arready during rhold", ARREADY4, 1'b0);
            @(posedge ACLK); #1;
            checkOutput("rvalid4 held", RVALID4, 1'b1);
            checkOutput("rdata4 stable", RDATA4, d4);
            checkOutput("rdata3 stable", RDATA3, d3);
            checkOutput("rresp3 stable", RRESP3, r3);
        end
        ARVALID = 1'b0;
        ARADDR  = addr;
        RREADY  = 1'b1;
        @(posedge ACLK); #1;
        RREADY  = 1'b0;
        checkOutput("rvalid4 cleared", RVALID4, 1'b0);
        checkOutput("rvalid3 cleared", RVALID3, 1'b0);
    endtask

    // Hard time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0]  r4, r3;
        logic [31:0] d4, d3, oldVal, exp4, exp3;
        logic [3:0]  addr;
        int          idx;

        vecs[0]  = '{1'b1, 4'h0, 32'h0000_0001, 4'hF, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00};
        vecs[1]  = '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 3, 0, 32'h0, 32'h0, 2'b00, 2'b00};
        vecs[2]  = '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00};
        vecs[3]  = '{1'b1, 4'hC, 32'h0000_0004, 4'hF, 0, 2, 32'h0, 32'h0, 2'b00, 2'b10};
        vecs[4]  = '{1'b0, 4'h0, 32'h0, 4'h0, 0, 0, 32'h0000_0001, 32'h0000_0001, 2'b00, 2'b00};
        vecs[5]  = '{1'b0, 4'h4, 32'h0, 4'h0, 0, 0, 32'h0000_0002, 32'h0000_0002, 2'b00, 2'b00};
        vecs[6]  = '{1'b0, 4'h8, 32'h0, 4'h0, 0, 0, 32'h0000_0003, 32'h0000_0003, 2'b00, 2'b00};
        vecs[7]  = '{1'b0, 4'hC, 32'h0, 4'h0, 0, 0, 32'h0000_0004, 32'h0000_0000, 2'b00, 2'b10};
        vecs[8]  = '{1'b1, 4'h0, 32'hAABB_CCDD, 4'hF, 1, 1, 32'h0, 32'h0, 2'b00, 2'b00};
        vecs[9]  = '{1'b1, 4'h0, 32'h1122_3344, 4'h5, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00};
        vecs[10] = '{1'b0, 4'h0, 32'h0, 4'h0, 0, 0, 32'hAA22_CC44, 32'hAA22_CC44, 2'b00, 2'b00};
        vecs[11] = '{1'b1, 4'h4, 32'hDEAD_BEEF, 4'h0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00};
        vecs[12] = '{1'b0, 4'h4, 32'h0, 4'h0, 0, 0, 32'h0000_0002, 32'h0000_0002, 2'b00, 2'b00};

        for (int k = 0; k < 4; k++) model4[k] = 32'h0;
        for (int k = 0; k < 3; k++) model3[k] = 32'h0;

        ARESET = 1'b1;
        AWADDR = 4'h0; AWPROT = 3'b000; AWVALID = 1'b0;
        WDATA = 32'h0; WSTRB = 4'h0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = 4'h0; ARPROT = 3'b000; ARVALID = 1'b0; RREADY = 1'b0;

        // Reset values while reset is held.
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("reset awready", AWREADY4, 1'b0);
        checkOutput("reset wready", WREADY4, 1'b0);
        checkOutput("reset arready", ARREADY4, 1'b0);
        checkOutput("reset bvalid", BVALID4, 1'b0);
        checkOutput("reset rvalid", RVALID4, 1'b0);
        checkOutput("reset bresp", BRESP4, 2'b00);
        checkOutput("reset rresp", RRESP4, 2'b00);
        checkOutput("reset rdata", RDATA4, 32'h0);
        checkOutput("reset pulse", pulse4, 4'b0000);
        checkRegs("reset");
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        checkOutput("awready before first edge", AWREADY4, 1'b0);
        @(posedge ACLK); #1;
        checkOutput("awready after release", AWREADY4, 1'b1);
        checkOutput("arready after release", ARREADY4, 1'b1);

        // Table-driven directed vectors.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].isWrite) begin
                applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].awDly, vecs[i].wDly, 0, r4, r3);
                checkOutput("table bresp4", r4, vecs[i].expResp4);
                checkOutput("table bresp3", r3, vecs[i].expResp3);
            end else begin
                readTxn(vecs[i].addr, 0, d4, d3, r4, r3);
                checkOutput("table rdata4", d4, vecs[i].expData4);
                checkOutput("table rdata3", d3, vecs[i].expData3);
                checkOutput("table rresp4", r4, vecs[i].expResp4);
                checkOutput("table rresp3", r3, vecs[i].expResp3);
            end
        end

        // Backpressure on B and R for five cycles, including an out-of-range write on dut3.
        applyStimulus(4'h8, 32'hCAFE_F00D, 4'hF, 0, 0, 5, r4, r3);
        applyStimulus(4'hC, 32'h7777_0000, 4'hC, 0, 0, 5, r4, r3);
        checkOutput("hold oor bresp3", r3, 2'b10);
        readTxn(4'h8, 5, d4, d3, r4, r3);
        checkOutput("hold rdata4", d4, 32'hCAFE_F00D);
        readTxn(4'hC, 5, d4, d3, r4, r3);
        checkOutput("hold oor rdata3", d3, 32'h0);
        checkOutput("hold oor rresp3", r3, 2'b10);
        checkOutput("hold rdata4 reg3", d4, 32'h7777_0004);

        // Read and write of the same register handshake in the same cycle: read sees the old value.
        oldVal  = model4[1];
        AWADDR  = 4'h4; WDATA = 32'h5555_AAAA; WSTRB = 4'hF; ARADDR = 4'h4;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        checkOutput("concurrent awready", AWREADY4, 1'b1);
        checkOutput("concurrent arready", ARREADY4, 1'b1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        model4[1] = 32'h5555_AAAA;
        model3[1] = 32'h5555_AAAA;
        checkOutput("concurrent bvalid", BVALID4, 1'b1);
        checkOutput("concurrent rvalid", RVALID4, 1'b1);
        checkOutput("concurrent old rdata", RDATA4, oldVal);
        checkOutput("concurrent pulse", pulse4, 4'b0010);
        checkRegs("concurrent");
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0; RREADY = 1'b0;
        checkOutput("concurrent bvalid cleared", BVALID4, 1'b0);
        checkOutput("concurrent rvalid cleared", RVALID4, 1'b0);

        // Randomized traffic against the register-array model.
        for (int i = 0; i < 40; i++) begin
            addr = 4'($urandom_range(0, 15));
            idx  = int'(addr[3:2]);
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(0, 1), r4, r3);
                checkOutput("rand bresp4", r4, 2'b00);
                checkOutput("rand bresp3", r3, (idx < 3) ? 2'b00 : 2'b10);
            end else begin
                exp4 = model4[idx];
                exp3 = (idx < 3) ? model3[idx] : 32'h0;
                readTxn(addr, $urandom_range(0, 2), d4, d3, r4, r3);
                checkOutput("rand rdata4", d4, exp4);
                checkOutput("rand rdata3", d3, exp3);
                checkOutput("rand rresp4", r4, 2'b00);
                checkOutput("rand rresp3", r3, (idx < 3) ? 2'b00 : 2'b10);
            end
        end

        // Reset asserted with AW accepted and W still pending.
        AWADDR  = 4'h8;
        AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        checkOutput("aw held awready", AWREADY4, 1'b0);
        checkOutput("aw held wready", WREADY4, 1'b1);
        #2;
        ARESET = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) model4[k] = 32'h0;
        for (int k = 0; k < 3; k++) model3[k] = 32'h0;
        checkOutput("midreset awready", AWREADY4, 1'b0);
        checkOutput("midreset wready", WREADY4, 1'b0);
        checkOutput("midreset arready", ARREADY4, 1'b0);
        checkOutput("midreset bvalid", BVALID4, 1'b0);
        checkOutput("midreset rdata", RDATA4, 32'h0);
        checkOutput("midreset pulse", pulse4, 4'b0000);
        checkRegs("midreset");
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        checkOutput("post reset awready", AWREADY4, 1'b1);
        checkOutput("post reset wready", WREADY4, 1'b1);
        applyStimulus(4'h8, 32'h1234_5678, 4'hF, 2, 0, 0, r4, r3);
        readTxn(4'h8, 0, d4, d3, r4, r3);
        checkOutput("post reset rdata4", d4, 32'h1234_5678);
        checkOutput("post reset rdata3", d3, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
